irq_ctrl: RTL and testbench

Eight-line interrupt request controller sitting directly downstream of the 8:3 priority encoder stage. It captures rising edges on eight request lines into a pending register, masks them, selects the highest-numbered enabled pending line with the same priority order as the encoder (bit 7 highest, bit 0 lowest), and presents its 3-bit index to a consumer over a valid/ack handshake. The pending bit of the presented line is cleared on acknowledge.

---
 rtl/irq_ctrl.sv | 82 ++++++++
 tb/tb_irq_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Eight-line interrupt controller: edge capture into a pending register, masking,
// fixed priority select (bit 7 highest) and a valid/ack presentation handshake.
module irq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ack,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending,
  output logic       overrun
);

  // state   | meaning
  // IDLE    | nothing presented; picks the top candidate on the next edge
  // PRESENT | irq_id held and valid until ack, no preemption
  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state, state_nxt;
  logic [7:0] req_q;
  logic [7:0] evt;
  logic [7:0] clr;
  logic [7:0] cand;
  logic [7:0] pending_nxt;
  logic       overrun_nxt;
  logic [2:0] id_nxt;

  function automatic logic [2:0] top_bit(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign irq_valid = (state == PRESENT);

  // A new edge on the line being acknowledged re-sets it and is not an overrun.
  always_comb begin
    evt         = req & ~req_q;
    clr         = (irq_valid && ack) ? (8'b1 << irq_id) : 8'b0;
    pending_nxt = (pending & ~clr) | evt;
    overrun_nxt = |(evt & pending & ~clr);
    cand        = pending & mask;
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    case (state)
      IDLE: begin
        if (cand != 8'b0) begin
          state_nxt = PRESENT;
          id_nxt    = top_bit(cand);
        end
      end
      PRESENT: begin
        if (ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      irq_id  <= 3'd0;
      req_q   <= 8'b0;
      pending <= 8'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      irq_id  <= id_nxt;
      req_q   <= req;
      pending <= pending_nxt;
      overrun <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios followed by random traffic, all checked
// every cycle against a bit-level behavioural model of the controller.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic       overrun;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0] m_pend;
  logic [7:0] m_reqq;
  logic       m_busy;
  logic [2:0] m_id;
  logic       m_ovr;

  irq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask      (mask),
    .ack       (ack),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applies one clock edge to the model using the inputs in force at that edge.
  task automatic model_edge();
    logic [7:0] np;
    logic       novr;
    int         clr_line;
    int         top;
    if (rst) begin
      m_pend = 8'h00; m_reqq = 8'h00; m_busy = 1'b0; m_id = 3'd0; m_ovr = 1'b0;
      return;
    end
    clr_line = (m_busy && ack) ? int'(m_id) : -1;
    novr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (req[i] && !m_reqq[i]) begin
        if (m_pend[i] && i != clr_line) novr = 1'b1;
        np[i] = 1'b1;
      end else if (i == clr_line) begin
        np[i] = 1'b0;
      end else begin
        np[i] = m_pend[i];
      end
    end
    if (m_busy) begin
      if (ack) m_busy = 1'b0;
    end else begin
      top = -1;
      for (int i = 7; i >= 0 && top < 0; i--)
        if (m_pend[i] && mask[i]) top = i;
      if (top >= 0) begin
        m_busy = 1'b1;
        m_id   = 3'(top);
      end
    end
    m_pend = np;
    m_ovr  = novr;
    m_reqq = req;
  endtask

  task automatic step(input logic r, input logic [7:0] q, input logic [7:0] m, input logic a);
    rst = r; req = q; mask = m; ack = a;
    @(posedge clk);
    model_edge();
    #1;
    chk("pending",   pending,          m_pend);
    chk("irq_valid", {7'b0, irq_valid}, {7'b0, m_busy});
    chk("irq_id",    {5'b0, irq_id},   {5'b0, m_id});
    chk("overrun",   {7'b0, overrun},  {7'b0, m_ovr});
  endtask

  initial begin
    logic [7:0] rq, mk;
    logic       ak;
    m_pend = 8'h00; m_reqq = 8'h00; m_busy = 1'b0; m_id = 3'd0; m_ovr = 1'b0;
    rst = 1'b1; req = 8'hFF; mask = 8'hFF; ack = 1'b0;

    // reset with requests held high, then release
    step(1, 8'hFF, 8'hFF, 0);
    step(1, 8'hFF, 8'hFF, 0);
    chk("rst_pending", pending, 8'h00);
    chk("rst_valid", {7'b0, irq_valid}, 8'h00);
    step(0, 8'hFF, 8'hFF, 0);
    chk("rel_pending", pending, 8'hFF);
    step(0, 8'hFF, 8'hFF, 0);
    chk("rel_valid", {7'b0, irq_valid}, 8'h01);
    chk("rel_id", {5'b0, irq_id}, 8'd7);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 8'hFF, m_busy);
    chk("drain", pending, 8'h00);

    // priority and handshake
    step(0, 8'h24, 8'hFF, 0);
    step(0, 8'h00, 8'hFF, 0);
    chk("prio_id5", {5'b0, irq_id}, 8'd5);
    step(0, 8'h00, 8'hFF, 1);
    chk("ack5_pend", pending, 8'h04);
    chk("ack5_idle", {7'b0, irq_valid}, 8'h00);
    step(0, 8'h00, 8'hFF, 0);
    chk("prio_id2", {5'b0, irq_id}, 8'd2);
    step(0, 8'h00, 8'hFF, 1);
    chk("ack2_pend", pending, 8'h00);
    step(0, 8'h00, 8'hFF, 0);
    chk("after_ack2", {7'b0, irq_valid}, 8'h00);

    // no preemption
    step(0, 8'h02, 8'hFF, 0);
    step(0, 8'h00, 8'hFF, 0);
    step(0, 8'h40, 8'hFF, 0);
    step(0, 8'h00, 8'hFF, 0);
    chk("nopre_id1", {5'b0, irq_id}, 8'd1);
    step(0, 8'h00, 8'hFF, 1);
    step(0, 8'h00, 8'hFF, 0);
    chk("nopre_id6", {5'b0, irq_id}, 8'd6);
    chk("nopre_valid", {7'b0, irq_valid}, 8'h01);
    step(0, 8'h00, 8'hFF, 1);

    // masking
    step(0, 8'h88, 8'h0F, 0);
    step(0, 8'h00, 8'h0F, 0);
    chk("mask_id3", {5'b0, irq_id}, 8'd3);
    step(0, 8'h00, 8'h0F, 1);
    chk("mask_keep7", pending, 8'h80);
    step(0, 8'h00, 8'h0F, 0);
    step(0, 8'h00, 8'h0F, 0);
    chk("mask_idle", {7'b0, irq_valid}, 8'h00);
    step(0, 8'h00, 8'hFF, 0);
    chk("unmask_id7", {5'b0, irq_id}, 8'd7);
    step(0, 8'h00, 8'hFF, 1);

    // overrun, then set-wins on ack
    step(0, 8'h10, 8'hFF, 0);
    step(0, 8'h00, 8'hFF, 0);
    step(0, 8'h10, 8'hFF, 0);
    chk("ovr_pulse", {7'b0, overrun}, 8'h01);
    step(0, 8'h00, 8'hFF, 0);
    chk("ovr_single", {7'b0, overrun}, 8'h00);
    step(0, 8'h10, 8'hFF, 1);
    chk("setwin_pend", pending, 8'h10);
    chk("setwin_novr", {7'b0, overrun}, 8'h00);
    step(0, 8'h00, 8'hFF, 0);
    chk("setwin_id4", {5'b0, irq_id}, 8'd4);
    chk("setwin_valid", {7'b0, irq_valid}, 8'h01);
    step(0, 8'h00, 8'hFF, 1);

    // stray ack, then reset while presenting
    step(0, 8'h00, 8'hFF, 1);
    chk("stray_valid", {7'b0, irq_valid}, 8'h00);
    step(0, 8'h81, 8'hFF, 0);
    chk("pend81", pending, 8'h81);
    step(0, 8'h00, 8'hFF, 0);
    chk("mid_valid", {7'b0, irq_valid}, 8'h01);
    step(1, 8'h00, 8'hFF, 0);
    chk("midrst_pend", pending, 8'h00);
    chk("midrst_valid", {7'b0, irq_valid}, 8'h00);

    // random traffic
    rq = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
      mk = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'hFF;
      ak = ($urandom_range(0, 2) != 0);
      step(($urandom_range(0, 99) == 0), rq, mk, ak);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
